// File: rtl/hilo_muldiv.sv
// hilo_muldiv: iterative MIPS-style HI/LO multiply/divide unit with MTHI/MTLO writes.
module hilo_muldiv (
  input  logic        clk,
  input  logic        reset_n_i,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] operand_a_i,
  input  logic [31:0] operand_b_i,
  input  logic        write_hi_i,
  input  logic        write_lo_i,
  input  logic [31:0] write_data_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);
  typedef enum logic [1:0] {IDLE, CALC, SIGN} state_t;
  state_t      state_q;
  logic [4:0]  cnt_q;
  logic [63:0] acc_q;
  logic [31:0] b_q, hi_q, lo_q;
  logic        div_q, neg_q, nega_q, div0_q, done_q;
  logic        sgn_d;
  logic [31:0] a_mag_d, b_mag_d;
  logic [32:0] add_d;
  logic [64:0] sh_d;
  logic [33:0] diff_d;
  logic [63:0] step_d, prod_d;
  // acc_q holds {partial, multiplier} for multiply and {remainder, quotient} for divide
  always_comb begin
    sgn_d   = ~op_i[0];
    a_mag_d = (sgn_d && operand_a_i[31]) ? -operand_a_i : operand_a_i;
    b_mag_d = (sgn_d && operand_b_i[31]) ? -operand_b_i : operand_b_i;
    add_d   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);
    sh_d    = {acc_q, 1'b0};
    diff_d  = {1'b0, sh_d[64:32]} - {2'b0, b_q};
    step_d  = div_q ? (diff_d[33] ? sh_d[63:0] : {diff_d[31:0], acc_q[30:0], 1'b1})
                    : {add_d, acc_q[31:1]};
    prod_d  = neg_q ? -acc_q : acc_q;
  end
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      nega_q  <= 1'b0;
      div0_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start_i) begin
          state_q <= CALC;
          cnt_q   <= '0;
          div_q   <= op_i[1];
          acc_q   <= {32'd0, a_mag_d};
          b_q     <= b_mag_d;
          neg_q   <= sgn_d & (operand_a_i[31] ^ operand_b_i[31]);
          nega_q  <= sgn_d & operand_a_i[31];
          div0_q  <= operand_b_i == 32'd0;
        end else begin
          if (write_hi_i) hi_q <= write_data_i;
          if (write_lo_i) lo_q <= write_data_i;
        end
        CALC: begin
          acc_q <= step_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_q <= SIGN;
        end
        SIGN: begin
          state_q <= IDLE;
          done_q  <= 1'b1;
          // a zero divisor leaves the all-ones quotient unsigned and |a| re-signed back to a
          if (div_q) begin
            lo_q <= (neg_q && !div0_q) ? -acc_q[31:0] : acc_q[31:0];
            hi_q <= nega_q ? -acc_q[63:32] : acc_q[63:32];
          end else {hi_q, lo_q} <= prod_d;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign busy_o = state_q != IDLE;
  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;
endmodule

// File: tb/tb_hilo_muldiv.sv
// tb_hilo_muldiv: directed self-checking bench for hilo_muldiv.
module tb_hilo_muldiv;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0, b = '0, wd = '0;
  logic        wh = 1'b0, wl = 1'b0;
  logic        busy, done;
  logic [31:0] hi, lo;
  logic [31:0] m_hi = '0, m_lo = '0;
  int checks = 0, failures = 0;

  hilo_muldiv dut (
    .clk(clk), .reset_n_i(reset_n), .start_i(start), .op_i(op),
    .operand_a_i(a), .operand_b_i(b), .write_hi_i(wh), .write_lo_i(wl),
    .write_data_i(wd), .busy_o(busy), .done_o(done), .hi_o(hi), .lo_o(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge one cycle after done.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic wh_at_start, input logic interfere,
                        input logic [31:0] ehi, input logic [31:0] elo);
    start = 1'b1; op = o; a = x; b = y; wh = wh_at_start; wd = 32'h0000_0055;
    @(posedge clk); @(negedge clk);
    start = 1'b0; wh = 1'b0; a = $urandom; b = $urandom;
    check({tag, " busy_at_start"}, {31'd0, busy}, 32'd1);
    for (int i = 1; i <= 32; i++) begin
      if (interfere && i == 10) begin
        start = 1'b1; op = 2'b11; a = 32'd9; b = 32'd3; wh = 1'b1; wd = 32'h0000_1234;
      end else begin
        start = 1'b0; wh = 1'b0;
      end
      @(posedge clk); @(negedge clk);
      check({tag, " busy_calc"}, {31'd0, busy}, 32'd1);
      check({tag, " done_calc"}, {31'd0, done}, 32'd0);
      check({tag, " hi_hold"}, hi, m_hi);
      check({tag, " lo_hold"}, lo, m_lo);
    end
    start = 1'b0; wh = 1'b0;
    @(posedge clk); @(negedge clk);
    check({tag, " busy_end"}, {31'd0, busy}, 32'd0);
    check({tag, " done_pulse"}, {31'd0, done}, 32'd1);
    check({tag, " hi"}, hi, ehi);
    check({tag, " lo"}, lo, elo);
    m_hi = ehi; m_lo = elo;
    @(posedge clk); @(negedge clk);
    check({tag, " done_after"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    #1;
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    run_op("mult_neg3x5", 2'b00, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("div_neg7by2", 2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu_by0", 2'b11, 32'd5, 32'd0, 1'b0, 1'b0, 32'h0000_0005, 32'hFFFF_FFFF);
    run_op("div_neg_by0", 2'b10, 32'hFFFF_FFF0, 32'd0, 1'b0, 1'b0, 32'hFFFF_FFF0, 32'hFFFF_FFFF);
    run_op("div_wrap", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0000_0000, 32'h8000_0000);
    run_op("multu_interfere", 2'b01, 32'd2, 32'd3, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_0006);
    run_op("start_beats_wr", 2'b01, 32'd1, 32'd1, 1'b1, 1'b0, 32'h0000_0000, 32'h0000_0001);
    wl = 1'b1; wd = 32'hDEAD_BEEF;
    @(posedge clk); @(negedge clk);
    wl = 1'b0;
    check("mtlo_lo", lo, 32'hDEAD_BEEF);
    check("mtlo_hi", hi, m_hi);
    check("mtlo_busy", {31'd0, busy}, 32'd0);
    wh = 1'b1; wl = 1'b1; wd = 32'hA5A5_A5A5;
    @(posedge clk); @(negedge clk);
    wh = 1'b0; wl = 1'b0;
    check("mt_both_hi", hi, 32'hA5A5_A5A5);
    check("mt_both_lo", lo, 32'hA5A5_A5A5);
    start = 1'b1; op = 2'b10; a = 32'd100; b = 32'd7;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    for (int i = 1; i < 20; i++) begin
      @(posedge clk); @(negedge clk);
    end
    check("abort_busy_before", {31'd0, busy}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("abort_no_done", {31'd0, done}, 32'd0);
    end
    m_hi = '0; m_lo = '0;
    reset_n = 1'b1;
    run_op("div_100by7", 2'b10, 32'd100, 32'd7, 1'b0, 1'b0, 32'h0000_0002, 32'h0000_000E);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
